flp_addnorm: RTL and testbench

FLP_ADDNORM -- requirements
Module: flp_addnorm

---
 rtl/flp_addnorm_if.sv | 32 +++
 rtl/flp_addnorm.sv | 153 +++++++++++++++
 tb/tb_flp_addnorm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flp_addnorm_if.sv
// Operand/result handshake bundle for flp_addnorm.
// The slave modport is the block's view; the master modport is the upstream/downstream driver's view.
interface flp_addnorm_if #(
  parameter int EWIDTH = 8,
  parameter int XWIDTH = 24
);
  logic              i_vld;
  logic              o_rdy;
  logic              i_s1;
  logic              i_s2;
  logic [XWIDTH-1:0] i_sg1;
  logic [XWIDTH-1:0] i_sg2;
  logic [EWIDTH-1:0] i_ex;
  logic              o_vld;
  logic              i_rdy;
  logic              o_s;
  logic [XWIDTH-1:0] o_sg;
  logic [EWIDTH-1:0] o_ex;
  logic              o_zero;
  logic              o_of;
  logic              o_uf;

  modport slave (
    input  i_vld, i_s1, i_s2, i_sg1, i_sg2, i_ex, i_rdy,
    output o_rdy, o_vld, o_s, o_sg, o_ex, o_zero, o_of, o_uf
  );

  modport master (
    output i_vld, i_s1, i_s2, i_sg1, i_sg2, i_ex, i_rdy,
    input  o_rdy, o_vld, o_s, o_sg, o_ex, o_zero, o_of, o_uf
  );
endinterface

// File: rtl/flp_addnorm.sv
// Two-stage floating-point significand add/subtract and normalize pipeline.
// Optional macro FLP_ADDNORM_JAM_EN: carry-case right shift ORs the dropped bit into the LSB.
module flp_addnorm #(
  parameter int EWIDTH = 8,
  parameter int XWIDTH = 24
) (
  input logic          clk,
  input logic          nrst,
  flp_addnorm_if.slave bus
);

  typedef struct packed {
    logic [XWIDTH-1:0] sg;
    logic [EWIDTH-1:0] ex;
    logic              zero;
    logic              of;
    logic              uf;
  } norm_t;

  function automatic logic [XWIDTH+1:0] addsub(input logic s1, input logic [XWIDTH-1:0] a,
                                               input logic s2, input logic [XWIDTH-1:0] b);
    logic            sgn;
    logic [XWIDTH:0] sum;
    if (s1 == s2) begin
      sum = {1'b0, a} + {1'b0, b};
      sgn = s1;
    end else if (a >= b) begin
      sum = {1'b0, a - b};
      sgn = (a == b) ? 1'b0 : s1;
    end else begin
      sum = {1'b0, b - a};
      sgn = s2;
    end
    return {sgn, sum};
  endfunction

  function automatic int lzc(input logic [XWIDTH-1:0] v);
    int n;
    n = XWIDTH;
    for (int i = 0; i < XWIDTH; i++) begin
      if (v[i]) n = XWIDTH - 1 - i;
    end
    return n;
  endfunction

  function automatic norm_t normalize(input logic [XWIDTH:0] sum, input logic [EWIDTH-1:0] ex);
    norm_t           r;
    logic [EWIDTH:0] exi;
    logic            jam;
    int              l;
    r   = '0;
    exi = '0;
    l   = 0;
`ifdef FLP_ADDNORM_JAM_EN
    jam = sum[0];
`else
    jam = 1'b0;
`endif
    if (sum[XWIDTH]) begin
      exi  = {1'b0, ex} + (EWIDTH+1)'(1);
      r.sg = sum[XWIDTH:1] | {{(XWIDTH-1){1'b0}}, jam};
      // Reaching the all-ones exponent saturates and flags overflow.
      if (exi >= {1'b0, {EWIDTH{1'b1}}}) begin
        r.ex = '1;
        r.of = 1'b1;
      end else begin
        r.ex = exi[EWIDTH-1:0];
      end
    end else if (sum == '0) begin
      r.zero = 1'b1;
    end else begin
      l = lzc(sum[XWIDTH-1:0]);
      if (l <= int'(ex)) begin
        r.sg = sum[XWIDTH-1:0] << l;
        r.ex = ex - EWIDTH'(l);
      end else begin
        r.sg = sum[XWIDTH-1:0] << ex;
        r.uf = 1'b1;
      end
    end
    return r;
  endfunction

  logic              vld_p1;
  logic              s_p1;
  logic [XWIDTH:0]   sum_p1;
  logic [EWIDTH-1:0] ex_p1;

  logic              vld_p2;
  logic              s_p2;
  logic [XWIDTH-1:0] sg_p2;
  logic [EWIDTH-1:0] ex_p2;
  logic              zero_p2;
  logic              of_p2;
  logic              uf_p2;

  logic  ld_p2;
  logic  rdy;
  norm_t nrm;

  assign ld_p2 = vld_p1 && (!vld_p2 || bus.i_rdy);
  assign rdy   = nrst && (!vld_p1 || ld_p2);
  assign nrm   = normalize(sum_p1, ex_p1);

  // Stage 1: add/subtract magnitudes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p1 <= 1'b0;
    end else if (rdy) begin
      vld_p1 <= bus.i_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && bus.i_vld) begin
      {s_p1, sum_p1} <= addsub(bus.i_s1, bus.i_sg1, bus.i_s2, bus.i_sg2);
      ex_p1          <= bus.i_ex;
    end
  end

  // Stage 2: normalize into the output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p2  <= 1'b0;
      s_p2    <= 1'b0;
      sg_p2   <= '0;
      ex_p2   <= '0;
      zero_p2 <= 1'b0;
      of_p2   <= 1'b0;
      uf_p2   <= 1'b0;
    end else if (ld_p2) begin
      vld_p2  <= 1'b1;
      s_p2    <= s_p1;
      sg_p2   <= nrm.sg;
      ex_p2   <= nrm.ex;
      zero_p2 <= nrm.zero;
      of_p2   <= nrm.of;
      uf_p2   <= nrm.uf;
    end else if (bus.i_rdy) begin
      vld_p2  <= 1'b0;
    end
  end

  assign bus.o_rdy  = rdy;
  assign bus.o_vld  = vld_p2;
  assign bus.o_s    = s_p2;
  assign bus.o_sg   = sg_p2;
  assign bus.o_ex   = ex_p2;
  assign bus.o_zero = zero_p2;
  assign bus.o_of   = of_p2;
  assign bus.o_uf   = uf_p2;

endmodule

// File: tb/tb_flp_addnorm.sv
// Self-checking bench for flp_addnorm: directed corner cases plus randomized
// traffic under backpressure, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_flp_addnorm;
  localparam int EW = 8;
  localparam int XW = 24;

  typedef struct packed {
    logic          s;
    logic [XW-1:0] sg;
    logic [EW-1:0] ex;
    logic          zero;
    logic          of;
    logic          uf;
  } res_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  flp_addnorm_if #(.EWIDTH(EW), .XWIDTH(XW)) bus ();
  flp_addnorm #(.EWIDTH(EW), .XWIDTH(XW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_out  = 0;
  res_t exp_q[$];
  res_t last_res;
  res_t prev_out;
  bit   prev_stall = 1'b0;
  bit   rand_rdy   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed sum of the operands, then scale into [2^(XW-1), 2^XW).
  function automatic res_t model(input bit s1, input logic [XW-1:0] a, input bit s2,
                                 input logic [XW-1:0] b, input logic [EW-1:0] e);
    res_t   r;
    longint v, mag;
    int     x;
    r   = '0;
    v   = (s1 ? -longint'(a) : longint'(a)) + (s2 ? -longint'(b) : longint'(b));
    mag = (v < 0) ? -v : v;
    x   = int'(e);
    if (mag == 0) begin
      r.s    = s1 & s2;
      r.zero = 1'b1;
      return r;
    end
    r.s = (v < 0);
    if (mag >= (longint'(1) << XW)) begin
`ifdef FLP_ADDNORM_JAM_EN
      mag = (mag >> 1) | (mag & 1);
`else
      mag = mag >> 1;
`endif
      x++;
      if (x >= (1 << EW) - 1) begin
        x    = (1 << EW) - 1;
        r.of = 1'b1;
      end
    end else begin
      while (mag < (longint'(1) << (XW-1)) && x > 0) begin
        mag = mag * 2;
        x--;
      end
      if (mag < (longint'(1) << (XW-1))) r.uf = 1'b1;
    end
    r.sg = mag[XW-1:0];
    r.ex = x[EW-1:0];
    return r;
  endfunction

  function automatic res_t cur_out();
    return {bus.o_s, bus.o_sg, bus.o_ex, bus.o_zero, bus.o_of, bus.o_uf};
  endfunction

  // Scoreboard: sampled on the falling edge, ahead of the next handshake edge.
  always @(negedge clk) begin
    res_t e;
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stable while stalled", 64'(cur_out()), 64'(prev_out));
      check("o_rdy", 64'(bus.o_rdy), 64'(!(exp_q.size() == 2 && bus.o_vld && !bus.i_rdy)));
      if (bus.o_vld && bus.i_rdy) begin
        if (exp_q.size() == 0) begin
          check("extra result", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(cur_out()), 64'(e));
          last_res = cur_out();
          n_out++;
        end
      end
      if (bus.i_vld && bus.o_rdy)
        exp_q.push_back(model(bus.i_s1, bus.i_sg1, bus.i_s2, bus.i_sg2, bus.i_ex));
      prev_stall = bus.o_vld && !bus.i_rdy;
      prev_out   = cur_out();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input bit s1, input logic [XW-1:0] a, input bit s2,
                      input logic [XW-1:0] b, input logic [EW-1:0] e);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    bus.i_vld = 1'b1;
    bus.i_s1  = s1;
    bus.i_sg1 = a;
    bus.i_s2  = s2;
    bus.i_sg2 = b;
    bus.i_ex  = e;
    do begin
      @(negedge clk);
      acc = bus.o_rdy;
      tick();
      t++;
    end while (!acc && t < 200);
    if (!acc) check("accept timeout", 64'(acc), 64'(1));
    bus.i_vld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic send_random();
    logic [XW-1:0] a, b;
    int            k;
    a = XW'($urandom_range(0, (1 << XW) - 1));
    k = $urandom_range(0, 3);
    if (k == 0)      b = a;
    else if (k == 1) b = a ^ XW'($urandom_range(0, 15));
    else             b = XW'($urandom_range(0, (1 << XW) - 1));
    send(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), b,
         EW'($urandom_range(0, (1 << EW) - 2)));
  endtask

  initial begin
    int   base;
    res_t want;
    bus.i_vld = 1'b0;
    bus.i_s1  = 1'b0;
    bus.i_s2  = 1'b0;
    bus.i_sg1 = '0;
    bus.i_sg2 = '0;
    bus.i_ex  = '0;
    bus.i_rdy = 1'b1;

    #12;
    check("reset o_vld",  64'(bus.o_vld),  64'(0));
    check("reset o_rdy",  64'(bus.o_rdy),  64'(0));
    check("reset o_s",    64'(bus.o_s),    64'(0));
    check("reset o_sg",   64'(bus.o_sg),   64'(0));
    check("reset o_ex",   64'(bus.o_ex),   64'(0));
    check("reset o_zero", 64'(bus.o_zero), 64'(0));
    check("reset o_of",   64'(bus.o_of),   64'(0));
    check("reset o_uf",   64'(bus.o_uf),   64'(0));
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("o_rdy after reset", 64'(bus.o_rdy), 64'(1));
    tick();

    // Carry case, with the two-cycle latency observed explicitly.
    send(1'b0, 24'h800000, 1'b0, 24'h800000, 8'h80);
    check("latency edge1 o_vld", 64'(bus.o_vld), 64'(0));
    tick();
    check("latency edge2 o_vld", 64'(bus.o_vld), 64'(1));
    drain();
    want = {1'b0, 24'h800000, 8'h81, 3'b000};
    check("carry", 64'(last_res), 64'(want));

    send(1'b0, 24'h800000, 1'b1, 24'h7FFFFF, 8'h80);
    drain();
    want = {1'b0, 24'h800000, 8'h69, 3'b000};
    check("cancellation", 64'(last_res), 64'(want));

    send(1'b0, 24'h123456, 1'b1, 24'h123456, 8'h80);
    drain();
    want = {1'b0, 24'h000000, 8'h00, 3'b100};
    check("exact cancel", 64'(last_res), 64'(want));

    send(1'b0, 24'h123456, 1'b1, 24'h123455, 8'h05);
    drain();
    want = {1'b0, 24'h000020, 8'h00, 3'b001};
    check("underflow", 64'(last_res), 64'(want));

    send(1'b0, 24'h800001, 1'b0, 24'h800000, 8'hFE);
    drain();
`ifdef FLP_ADDNORM_JAM_EN
    want = {1'b0, 24'h800001, 8'hFF, 3'b010};
`else
    want = {1'b0, 24'h800000, 8'hFF, 3'b010};
`endif
    check("overflow", 64'(last_res), 64'(want));

    // Eight transfers under pseudo-random backpressure.
    base     = n_out;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send_random();
    drain();
    check("backpressure count", 64'(n_out - base), 64'(8));

    // Longer random run.
    base = n_out;
    for (int i = 0; i < 60; i++) send_random();
    drain();
    check("random count", 64'(n_out - base), 64'(60));
    rand_rdy  = 1'b0;
    bus.i_rdy = 1'b1;
    tick();

    // Fill both stages, then reset mid-stream.
    bus.i_rdy = 1'b0;
    base      = n_out;
    send(1'b0, 24'h400000, 1'b0, 24'h400000, 8'h10);
    send(1'b1, 24'h300000, 1'b0, 24'h100000, 8'h20);
    check("full o_vld", 64'(bus.o_vld), 64'(1));
    check("full o_rdy", 64'(bus.o_rdy), 64'(0));
    #2;
    nrst = 1'b0;
    #1;
    check("mid reset o_vld", 64'(bus.o_vld), 64'(0));
    check("mid reset o_rdy", 64'(bus.o_rdy), 64'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    nrst      = 1'b1;
    bus.i_rdy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("no stale o_vld", 64'(bus.o_vld), 64'(0));
      tick();
    end
    check("no stale count", 64'(n_out - base), 64'(0));

    send(1'b1, 24'h800000, 1'b1, 24'h800000, 8'h40);
    drain();
    want = {1'b1, 24'h800000, 8'h41, 3'b000};
    check("post reset", 64'(last_res), 64'(want));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
